// File: rtl/bp_me_mem_cmd_arb.sv
// bp_me_mem_cmd_arb
// Arbitrates memory commands from num_cce_p CCEs onto a single memory port.
// The winning command is held in one output register slot. The source ID of
// every issued command is queued so that in-order memory responses can be
// routed back to the CCE that issued them. The number of issued but unanswered
// commands is bounded by max_outstanding_p.
// Build option: define BP_ME_MEM_ARB_FIXED_PRIO_EN to replace the default
// round-robin arbiter with fixed priority, where the lowest valid index wins.
module bp_me_mem_cmd_arb #(
    parameter int num_cce_p         = 2,
    parameter int cmd_width_p       = 64,
    parameter int max_outstanding_p = 4,
    localparam int src_w_lp = (num_cce_p > 1) ? $clog2(num_cce_p) : 1
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,
    input  logic [num_cce_p-1:0][cmd_width_p-1:0] mem_cmd_i,
    input  logic [num_cce_p-1:0]                  mem_cmd_v_i,
    output logic [num_cce_p-1:0]                  mem_cmd_yumi_o,
    output logic [cmd_width_p-1:0]                mem_cmd_o,
    output logic [src_w_lp-1:0]                   mem_cmd_src_o,
    output logic                                  mem_cmd_v_o,
    input  logic                                  mem_cmd_ready_i,
    input  logic                                  mem_resp_v_i,
    output logic                                  mem_resp_ready_o,
    output logic [src_w_lp-1:0]                   mem_resp_dst_o
);

    localparam int ptr_w_lp = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
    localparam int cnt_w_lp = $clog2(max_outstanding_p + 1);

    // Output slot
    logic                   slot_v_q, slot_v_d;
    logic [cmd_width_p-1:0] slot_cmd_q, slot_cmd_d;
    logic [src_w_lp-1:0]    slot_src_q, slot_src_d;

    // Source-ID FIFO; storage is not reset, pointers and count are
    logic [src_w_lp-1:0]    fifo_mem [max_outstanding_p];
    logic [ptr_w_lp-1:0]    rd_ptr_q, rd_ptr_d;
    logic [ptr_w_lp-1:0]    wr_ptr_q, wr_ptr_d;
    logic [cnt_w_lp-1:0]    cnt_q, cnt_d;

    // High during reset and for the first cycle after it; blocks grants
    logic                   rst_hold_q;

    logic                   handshake;
    logic                   fifo_push;
    logic                   fifo_pop;
    logic [cnt_w_lp:0]      outstanding;
    logic                   permit;
    logic                   win_found;
    logic [src_w_lp-1:0]    win_idx;
    logic                   grant;

    assign handshake   = slot_v_q & mem_cmd_ready_i;
    assign fifo_push   = handshake;
    assign fifo_pop    = mem_resp_v_i & (cnt_q != '0);
    // A response popped this cycle frees its credit only on the next cycle
    assign outstanding = {1'b0, cnt_q} + (cnt_w_lp + 1)'(slot_v_q);
    assign permit      = outstanding < (cnt_w_lp + 1)'(max_outstanding_p);
    assign grant       = win_found & permit & ~reset_i & ~rst_hold_q
                       & (~slot_v_q | handshake);

`ifdef BP_ME_MEM_ARB_FIXED_PRIO_EN
    // Fixed priority: scan from the top so the lowest valid index is kept last
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = num_cce_p - 1; i >= 0; i--) begin
            if (mem_cmd_v_i[i]) begin
                win_found = 1'b1;
                win_idx   = src_w_lp'(i);
            end
        end
    end
`else
    logic [src_w_lp-1:0] last_grant_q;

    // Round-robin: first valid source at or after last_grant+1, wrapping
    always_comb begin
        int                  cand;
        logic [src_w_lp-1:0] cand_idx;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 0; i < num_cce_p; i++) begin
            cand = int'(last_grant_q) + 1 + i;
            if (cand >= num_cce_p) begin
                cand = cand - num_cce_p;
            end
            cand_idx = src_w_lp'(cand);
            if (!win_found && mem_cmd_v_i[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    // Remember the most recent winner; index 0 is searched first after reset
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            last_grant_q <= src_w_lp'(num_cce_p - 1);
        end else if (grant) begin
            last_grant_q <= win_idx;
        end
    end
`endif

    // Acknowledge exactly the winning source in the grant cycle
    for (genvar gi = 0; gi < num_cce_p; gi++) begin : g_yumi
        assign mem_cmd_yumi_o[gi] = grant & (win_idx == src_w_lp'(gi));
    end

    // Slot next state: load on grant, otherwise drain on handshake
    always_comb begin
        slot_v_d   = slot_v_q;
        slot_cmd_d = slot_cmd_q;
        slot_src_d = slot_src_q;
        if (grant) begin
            slot_v_d   = 1'b1;
            slot_cmd_d = mem_cmd_i[win_idx];
            slot_src_d = win_idx;
        end else if (handshake) begin
            slot_v_d   = 1'b0;
        end
    end

    // FIFO pointer and occupancy next state
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (fifo_push) begin
            wr_ptr_d = (wr_ptr_q == ptr_w_lp'(max_outstanding_p - 1)) ? '0
                     : wr_ptr_q + ptr_w_lp'(1);
        end
        if (fifo_pop) begin
            rd_ptr_d = (rd_ptr_q == ptr_w_lp'(max_outstanding_p - 1)) ? '0
                     : rd_ptr_q + ptr_w_lp'(1);
        end
        if (fifo_push && !fifo_pop) begin
            cnt_d = cnt_q + cnt_w_lp'(1);
        end else if (!fifo_push && fifo_pop) begin
            cnt_d = cnt_q - cnt_w_lp'(1);
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            slot_v_q   <= 1'b0;
            slot_cmd_q <= '0;
            slot_src_q <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            cnt_q      <= '0;
        end else begin
            slot_v_q   <= slot_v_d;
            slot_cmd_q <= slot_cmd_d;
            slot_src_q <= slot_src_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            cnt_q      <= cnt_d;
        end
    end

    // Grant blocker follows reset with one cycle of extension
    always_ff @(posedge clk_i) begin
        rst_hold_q <= reset_i;
    end

    // Record the source of each command as it leaves the slot
    always_ff @(posedge clk_i) begin
        if (fifo_push && !reset_i) begin
            fifo_mem[wr_ptr_q] <= slot_src_q;
        end
    end

    assign mem_cmd_o        = slot_cmd_q;
    assign mem_cmd_src_o    = slot_src_q;
    assign mem_cmd_v_o      = slot_v_q;
    assign mem_resp_ready_o = (cnt_q != '0);
    // Gate the head read so the output is defined while the FIFO is empty
    assign mem_resp_dst_o   = (cnt_q != '0) ? fifo_mem[rd_ptr_q] : '0;

endmodule

// File: tb/tb_bp_me_mem_cmd_arb.sv
// Directed testbench for bp_me_mem_cmd_arb (num_cce_p=2, max_outstanding_p=4).
// Expectations follow the round-robin arbiter unless the bench is built with
// BP_ME_MEM_ARB_FIXED_PRIO_EN, in which case index 0 always wins.
module tb_bp_me_mem_cmd_arb;

    localparam int N  = 2;
    localparam int W  = 64;
    localparam int MO = 4;

`ifdef BP_ME_MEM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic                clk_i = 1'b0;
    logic                reset_i;
    logic [N-1:0][W-1:0] mem_cmd_i;
    logic [N-1:0]        mem_cmd_v_i;
    logic [N-1:0]        mem_cmd_yumi_o;
    logic [W-1:0]        mem_cmd_o;
    logic [0:0]          mem_cmd_src_o;
    logic                mem_cmd_v_o;
    logic                mem_cmd_ready_i;
    logic                mem_resp_v_i;
    logic                mem_resp_ready_o;
    logic [0:0]          mem_resp_dst_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    bp_me_mem_cmd_arb #(
        .num_cce_p        (N),
        .cmd_width_p      (W),
        .max_outstanding_p(MO)
    ) dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .mem_cmd_i       (mem_cmd_i),
        .mem_cmd_v_i     (mem_cmd_v_i),
        .mem_cmd_yumi_o  (mem_cmd_yumi_o),
        .mem_cmd_o       (mem_cmd_o),
        .mem_cmd_src_o   (mem_cmd_src_o),
        .mem_cmd_v_o     (mem_cmd_v_o),
        .mem_cmd_ready_i (mem_cmd_ready_i),
        .mem_resp_v_i    (mem_resp_v_i),
        .mem_resp_ready_o(mem_resp_ready_o),
        .mem_resp_dst_o  (mem_resp_dst_o)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] make_cmd(input int src, input int gen);
        return 64'hA5A5_0000_0000_0000 | (64'(gen) << 8) | 64'(src);
    endfunction

    task automatic drive_cmds(input int gen);
        for (int i = 0; i < N; i++) mem_cmd_i[i] = make_cmd(i, gen);
    endtask

    task automatic cyc();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    // Reset for two cycles, then step past the post-reset hold cycle
    task automatic do_reset();
        reset_i      = 1'b1;
        mem_cmd_v_i  = '0;
        mem_resp_v_i = 1'b0;
        drive_cmds(0);
        cyc();
        cyc();
        reset_i = 1'b0;
        cyc();
    endtask

    // One line per command handshake and per routed response
    always @(posedge clk_i) begin
        if (!reset_i && mem_cmd_v_o && mem_cmd_ready_i)
            $display("cmd  src=%0d data=%h", mem_cmd_src_o, mem_cmd_o);
        if (!reset_i && mem_resp_v_i && mem_resp_ready_o)
            $display("resp dst=%0d", mem_resp_dst_o);
    end

    initial begin
        int exp_idx;
        int n_y;
        int n_h;

        // ---- reset behaviour, then steady alternation with immediate responses
        reset_i         = 1'b1;
        mem_cmd_v_i     = 2'b11;
        mem_cmd_ready_i = 1'b1;
        mem_resp_v_i    = 1'b1;
        drive_cmds(0);
        @(negedge clk_i);
        cyc();
        #1;
        check_eq("rst_v",     64'(mem_cmd_v_o),      64'(0));
        check_eq("rst_yumi",  64'(mem_cmd_yumi_o),   64'(0));
        check_eq("rst_rready",64'(mem_resp_ready_o), 64'(0));
        check_eq("rst_dst",   64'(mem_resp_dst_o),   64'(0));
        reset_i = 1'b0;
        #1;
        check_eq("hold_yumi",   64'(mem_cmd_yumi_o),   64'(0));
        check_eq("hold_v",      64'(mem_cmd_v_o),      64'(0));
        check_eq("hold_rready", 64'(mem_resp_ready_o), 64'(0));
        cyc();
        for (int c = 0; c < 8; c++) begin
            #1;
            exp_idx = FIXED ? 0 : (c % 2);
            check_eq("t1_yumi", 64'(mem_cmd_yumi_o), 64'(1) << exp_idx);
            if (c >= 1) begin
                exp_idx = FIXED ? 0 : ((c - 1) % 2);
                check_eq("t1_v",   64'(mem_cmd_v_o),   64'(1));
                check_eq("t1_src", 64'(mem_cmd_src_o), 64'(exp_idx));
                check_eq("t1_cmd", mem_cmd_o,          make_cmd(exp_idx, 0));
            end
            if (c >= 2) begin
                exp_idx = FIXED ? 0 : ((c - 2) % 2);
                check_eq("t1_rready", 64'(mem_resp_ready_o), 64'(1));
                check_eq("t1_dst",    64'(mem_resp_dst_o),   64'(exp_idx));
            end
            cyc();
        end

        // ---- outstanding limit with no responses
        do_reset();
        mem_cmd_v_i     = 2'b11;
        mem_cmd_ready_i = 1'b1;
        n_y = 0;
        n_h = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (mem_cmd_yumi_o != '0) n_y++;
            if (mem_cmd_v_o && mem_cmd_ready_i) n_h++;
            cyc();
        end
        #1;
        check_eq("t2_grants",     64'(n_y),              64'(4));
        check_eq("t2_handshakes", 64'(n_h),              64'(4));
        check_eq("t2_yumi_stall", 64'(mem_cmd_yumi_o),   64'(0));
        check_eq("t2_v",          64'(mem_cmd_v_o),      64'(0));
        check_eq("t2_rready",     64'(mem_resp_ready_o), 64'(1));
        check_eq("t2_dst_first",  64'(mem_resp_dst_o),   64'(0));
        mem_resp_v_i = 1'b1;
        #1;
        check_eq("t2_no_credit", 64'(mem_cmd_yumi_o), 64'(0));
        cyc();
        mem_resp_v_i = 1'b0;
        #1;
        check_eq("t2_regrant",   64'(mem_cmd_yumi_o), 64'(1));
        check_eq("t2_dst_second",64'(mem_resp_dst_o), FIXED ? 64'(0) : 64'(1));
        mem_cmd_v_i = '0;
        cyc();

        // ---- back-pressure: slot must hold while ready is low
        do_reset();
        mem_cmd_v_i     = 2'b11;
        mem_cmd_ready_i = 1'b0;
        #1;
        check_eq("t3_first_yumi", 64'(mem_cmd_yumi_o), 64'(1));
        cyc();
        drive_cmds(1);
        for (int c = 0; c < 5; c++) begin
            #1;
            check_eq("t3_v",    64'(mem_cmd_v_o),    64'(1));
            check_eq("t3_src",  64'(mem_cmd_src_o),  64'(0));
            check_eq("t3_cmd",  mem_cmd_o,           make_cmd(0, 0));
            check_eq("t3_yumi", 64'(mem_cmd_yumi_o), 64'(0));
            cyc();
        end
        mem_cmd_ready_i = 1'b1;
        #1;
        check_eq("t3_release_yumi", 64'(mem_cmd_yumi_o), FIXED ? 64'(1) : 64'(2));
        cyc();
        #1;
        exp_idx = FIXED ? 0 : 1;
        check_eq("t3_next_src", 64'(mem_cmd_src_o), 64'(exp_idx));
        check_eq("t3_next_cmd", mem_cmd_o,          make_cmd(exp_idx, 1));
        mem_cmd_v_i = '0;
        cyc();

        // ---- response valid while FIFO empty is ignored
        do_reset();
        mem_cmd_ready_i = 1'b1;
        mem_resp_v_i    = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            check_eq("t4_rready_empty", 64'(mem_resp_ready_o), 64'(0));
            cyc();
        end
        mem_resp_v_i = 1'b0;
        mem_cmd_v_i  = 2'b01;
        #1;
        check_eq("t4_yumi", 64'(mem_cmd_yumi_o), 64'(1));
        cyc();
        mem_cmd_v_i = '0;
        #1;
        check_eq("t4_v",       64'(mem_cmd_v_o),      64'(1));
        check_eq("t4_rready0", 64'(mem_resp_ready_o), 64'(0));
        cyc();
        #1;
        check_eq("t4_rready1", 64'(mem_resp_ready_o), 64'(1));
        check_eq("t4_dst",     64'(mem_resp_dst_o),   64'(0));
        mem_resp_v_i = 1'b1;
        cyc();
        mem_resp_v_i = 1'b0;
        #1;
        check_eq("t4_drained", 64'(mem_resp_ready_o), 64'(0));

        // ---- reset in the middle of operation with 3 outstanding
        do_reset();
        mem_cmd_v_i     = 2'b11;
        mem_cmd_ready_i = 1'b1;
        cyc();
        cyc();
        cyc();
        mem_cmd_v_i = '0;
        #1;
        check_eq("t5_pre_rready", 64'(mem_resp_ready_o), 64'(1));
        check_eq("t5_pre_v",      64'(mem_cmd_v_o),      64'(1));
        reset_i     = 1'b1;
        mem_cmd_v_i = 2'b11;
        #1;
        check_eq("t5_rst_yumi", 64'(mem_cmd_yumi_o), 64'(0));
        cyc();
        reset_i = 1'b0;
        #1;
        check_eq("t5_post_v",      64'(mem_cmd_v_o),      64'(0));
        check_eq("t5_post_rready", 64'(mem_resp_ready_o), 64'(0));
        check_eq("t5_post_yumi",   64'(mem_cmd_yumi_o),   64'(0));
        cyc();
        #1;
        check_eq("t5_first_grant", 64'(mem_cmd_yumi_o), 64'(1));
        cyc();
        #1;
        check_eq("t5_first_src", 64'(mem_cmd_src_o), 64'(0));
        mem_cmd_v_i = '0;
        cyc();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
